button_debounce: RTL and testbench
==================================

# button_debounce

Conditions a raw mechanical push-button into a clean, glitch-free level plus event strobes. It sits directly upstream of the open-drain line driver: its `btn_level` output drives that block's `button` input, so the shared line is only pulled low on a debounced press. It also provides press/release pulses, a long-press flag and a wrapping press counter for status LEDs and software-visible logic.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal minimum 2.
- `LONG_CYCLES`, default 50000000: accepted-press duration, in cycles, before `long_press` asserts (1 s at 50 MHz); must exceed `DEBOUNCE_CYCLES`.
- `CNT_W`, default 26: width of the internal timer; must hold `LONG_CYCLES`.

Ports:
- `clk`  input  1  system clock, rising-edge active.
- `rst`  input  1  asynchronous, active-low reset.
- `btn_raw`  input  1  raw pad input, active-high (1 = pressed), asynchronous to `clk`, may bounce.
- `btn_level`  output  1  debounced level, 1 = pressed.
- `press_pulse`  output  1  one-cycle strobe on accepted press.
- `release_pulse`  output  1  one-cycle strobe on accepted release.
- `long_press`  output  1  high while an accepted press has lasted `LONG_CYCLES`.
- `press_count`  output  8  number of accepted presses, modulo 256.

## Operation

- **Reset** (`rst` = 0, asynchronous):
  - Synchronizer flops = 0.
  - Timer = 0.
  - State = RELEASED.
  - All outputs = 0.
- **Synchronizer:** `btn_raw` passes through two flops (`s1`, `s2`). Only `s2` is used downstream.
- **States:**
  - RELEASED: `btn_level` = 0, timer held at 0. If `s2` = 1, go to PRESS_CHK with timer = 1.
  - PRESS_CHK:
    - If `s2` = 0, return to RELEASED and clear the timer (bounce rejected, no outputs change).
    - If the timer = `DEBOUNCE_CYCLES`, go to PRESSED, clear the timer, and register all of:
      - `btn_level` = 1
      - `press_pulse` = 1 for one cycle
      - `press_count` += 1, wrapping 255 to 0
    - Otherwise increment the timer.
  - PRESSED:
    - The timer counts press duration, saturating at `LONG_CYCLES`.
    - When the timer reaches `LONG_CYCLES`, `long_press` is set and stays 1.
    - If `s2` = 0, go to RELEASE_CHK with timer = 1. Keep `long_press` unchanged.
  - RELEASE_CHK:
    - If `s2` = 1, return to PRESSED. The duration timer restarts from 0, but `long_press` keeps its value.
    - If the timer = `DEBOUNCE_CYCLES`, go to RELEASED and register all of:
      - `btn_level` = 0
      - `release_pulse` = 1 for one cycle
      - `long_press` = 0
    - Otherwise increment the timer.
- **Output register rules:**
  - All outputs are registered. There are no combinational paths from `btn_raw`.
  - `press_pulse` and `release_pulse` are never high in the same cycle.

## Timing

- **Press latency:** with `btn_raw` stable high, `btn_level` and `press_pulse` rise exactly `DEBOUNCE_CYCLES` + 3 rising edges after the first edge that samples `btn_raw` = 1 into `s1`.
  - 2 edges synchronizer.
  - 1 edge RELEASED to PRESS_CHK.
  - `DEBOUNCE_CYCLES` edges of counting.
- **Release latency:** identical, `DEBOUNCE_CYCLES` + 3 edges.
- **Long-press latency:** `long_press` rises `LONG_CYCLES` + 1 edges after `btn_level` rises, provided there is no qualified release and no bounce back into PRESSED.
- **Bounce rejection:** any glitch shorter than `DEBOUNCE_CYCLES` cycles at `s2` restarts qualification. No pulse is emitted and `press_count` is unchanged.
- **Counter wrap:** the 256th accepted press returns `press_count` to 0.
- **Reset mid-operation:** outputs clear immediately (asynchronously). After `rst` deasserts, a still-held button is re-qualified as a new press, giving a `press_pulse` and `press_count` = 1.
- **Reset release:** the first accepted press after reset cannot occur sooner than `DEBOUNCE_CYCLES` + 3 edges after `rst` deasserts.

## Test plan

Bench uses `DEBOUNCE_CYCLES` = 4 and `LONG_CYCLES` = 20.

1. **Reset values:** hold `rst` = 0 with `btn_raw` = 1.
   - Required: all outputs 0 throughout.
   - Then release `rst` with `btn_raw` still 1: `btn_level` rises 7 edges later, `press_pulse` is high for exactly 1 cycle, `press_count` = 1.
2. **Clean press and release:** raise `btn_raw` and hold 30 cycles, then drop it.
   - Press: `btn_level` rises 7 edges after the rise.
   - Long press: `long_press` rises 21 edges after `btn_level`.
   - Release: `btn_level`, `long_press` and `release_pulse` respond 7 edges after the drop. `release_pulse` is 1 cycle wide.
3. **Bounce rejection:** toggle `btn_raw` as high 3, low 1, high 2, low 10 cycles.
   - Required: `btn_level` stays 0, no pulses, `press_count` unchanged.
4. **Release bounce:** while PRESSED, drop `btn_raw` for 3 cycles, then restore it.
   - Required: `btn_level` stays 1, no `release_pulse`, `long_press` unaffected.
5. **Counter wrap:** apply 257 clean presses.
   - Required: `press_count` reads 255 after press 255, 0 after press 256, 1 after press 257.
6. **Reset mid-press:** assert `rst` during PRESS_CHK and again during PRESSED with `long_press` = 1.
   - Required: outputs clear immediately.
   - After `rst` deasserts with the button still held, re-qualification takes 7 edges.

Source files
------------

// File: rtl/button_debounce.sv
// button_debounce: conditions a raw, bouncing push-button into a clean level
// with press/release strobes, a long-press flag and a wrapping press counter.
//
// Ports:
//   clk           system clock, rising-edge active
//   rst           asynchronous active-low reset
//   btn_raw       raw pad input (1 = pressed), asynchronous, may bounce
//   btn_level     debounced level (1 = pressed)
//   press_pulse   one-cycle strobe on an accepted press
//   release_pulse one-cycle strobe on an accepted release
//   long_press    high once an accepted press has lasted LONG_CYCLES
//   press_count   accepted presses, modulo 256
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned CNT_W           = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_raw,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_press,
    output logic [7:0] press_count
);

    localparam logic [1:0] RELEASED    = 2'd0;
    localparam logic [1:0] PRESS_CHK   = 2'd1;
    localparam logic [1:0] PRESSED     = 2'd2;
    localparam logic [1:0] RELEASE_CHK = 2'd3;

    localparam logic [CNT_W-1:0] DEB_T  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LONG_T = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] ONE_T  = CNT_W'(1);

    logic             s1, s2;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             level_d, press_d, release_d, long_d;
    logic [7:0]       count_d;

    // Two-flop synchronizer for the asynchronous pad input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    // State, timer and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RELEASED;
            timer_q       <= '0;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_press    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            btn_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            long_press    <= long_d;
            press_count   <= count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        level_d   = btn_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = long_press;
        count_d   = press_count;

        unique case (state_q)
            RELEASED: begin
                timer_d = '0;
                if (s2) begin
                    state_d = PRESS_CHK;
                    timer_d = ONE_T;
                end
            end
            PRESS_CHK: begin
                if (!s2) begin
                    state_d = RELEASED;
                    timer_d = '0;
                end else if (timer_q == DEB_T) begin
                    state_d = PRESSED;
                    timer_d = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    count_d = press_count + 8'd1;
                end else begin
                    timer_d = timer_q + ONE_T;
                end
            end
            PRESSED: begin
                // Flag is registered from the saturated timer, so it lands one
                // edge after the timer reaches LONG_CYCLES.
                if (timer_q == LONG_T) begin
                    long_d = 1'b1;
                end
                if (!s2) begin
                    state_d = RELEASE_CHK;
                    timer_d = ONE_T;
                end else if (timer_q != LONG_T) begin
                    timer_d = timer_q + ONE_T;
                end
            end
            RELEASE_CHK: begin
                if (s2) begin
                    state_d = PRESSED;
                    timer_d = '0;
                end else if (timer_q == DEB_T) begin
                    state_d   = RELEASED;
                    timer_d   = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    long_d    = 1'b0;
                end else begin
                    timer_d = timer_q + ONE_T;
                end
            end
            default: begin
                state_d = RELEASED;
                timer_d = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
module tb_button_debounce;

    localparam int unsigned DEB  = 4;
    localparam int unsigned LONG = 20;
    localparam int          LAT  = DEB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_raw;
    logic       btn_level, press_pulse, release_pulse, long_press;
    logic [7:0] press_count;

    typedef struct {
        bit         is_press;
        logic [7:0] count;
    } ev_t;

    ev_t        sb[$];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_count = 8'd0;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_raw      (btn_raw),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_press   (long_press),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // sel 0 = btn_level, 1 = long_press; bounded wait, returns edges elapsed
    task automatic wait_for(input int sel, input logic v, input int maxc, output int n);
        n = 0;
        while (((sel == 0) ? btn_level : long_press) !== v && n < maxc) begin
            tick();
            n++;
        end
    endtask

    task automatic push_press();
        ev_t e;
        exp_count  = exp_count + 8'd1;
        e.is_press = 1'b1;
        e.count    = exp_count;
        sb.push_back(e);
    endtask

    task automatic push_release();
        ev_t e;
        e.is_press = 1'b0;
        e.count    = exp_count;
        sb.push_back(e);
    endtask

    task automatic all_zero(input string tag);
        check(tag, 32'({btn_level, press_pulse, release_pulse, long_press, press_count}), 32'd0);
    endtask

    // Pulse monitor: every strobe must match the next expected event
    always @(posedge clk) begin
        ev_t e;
        #1;
        if (press_pulse || release_pulse) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({press_pulse, release_pulse}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 32'({press_pulse, release_pulse}), e.is_press ? 32'd2 : 32'd1);
                check("pulse_count", 32'(press_count), 32'(e.count));
                check("pulse_level", 32'(btn_level), e.is_press ? 32'd1 : 32'd0);
                if (!e.is_press) check("release_long", 32'(long_press), 32'd0);
            end
        end
    end

    initial begin
        int n;
        logic seen_level, seen_long_drop;
        logic [7:0] c0;

        // 1. reset values with button held, then re-qualification
        rst = 1'b0;
        btn_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            all_zero("reset_hold");
        end
        rst = 1'b1;
        push_press();
        wait_for(0, 1'b1, 20, n);
        check("rst_release_lat", 32'(n), 32'(LAT));
        btn_raw = 1'b0;
        push_release();
        wait_for(0, 1'b0, 20, n);
        check("rel_lat_1", 32'(n), 32'(LAT));

        // 2. clean press with long-press, then release
        tick();
        btn_raw = 1'b1;
        push_press();
        wait_for(0, 1'b1, 20, n);
        check("press_lat", 32'(n), 32'(LAT));
        wait_for(1, 1'b1, 40, n);
        check("long_lat", 32'(n), 32'(LONG + 1));
        tick();
        tick();
        check("long_held", 32'(long_press), 32'd1);
        btn_raw = 1'b0;
        push_release();
        wait_for(0, 1'b0, 20, n);
        check("release_lat", 32'(n), 32'(LAT));
        check("long_cleared", 32'(long_press), 32'd0);

        // 3. bounce rejection: high 3, low 1, high 2, low 10
        c0 = press_count;
        seen_level = 1'b0;
        for (int i = 0; i < 16; i++) begin
            btn_raw = (i < 3) || (i >= 4 && i < 6);
            tick();
            seen_level |= btn_level;
        end
        check("bounce_level", 32'(seen_level), 32'd0);
        check("bounce_count", 32'(press_count), 32'(c0));

        // 4. release bounce while pressed with long_press set
        btn_raw = 1'b1;
        push_press();
        wait_for(0, 1'b1, 20, n);
        check("press_lat_4", 32'(n), 32'(LAT));
        wait_for(1, 1'b1, 40, n);
        check("long_lat_4", 32'(n), 32'(LONG + 1));
        btn_raw = 1'b0;
        seen_level = 1'b1;
        seen_long_drop = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (i == 3) btn_raw = 1'b1;
            tick();
            seen_level &= btn_level;
            seen_long_drop |= ~long_press;
        end
        check("relbounce_level", 32'(seen_level), 32'd1);
        check("relbounce_long", 32'(seen_long_drop), 32'd0);
        btn_raw = 1'b0;
        push_release();
        wait_for(0, 1'b0, 20, n);
        check("release_lat_4", 32'(n), 32'(LAT));

        // 5. counter wrap from a fresh reset
        rst = 1'b0;
        #1;
        all_zero("reset_clear_5");
        exp_count = 8'd0;
        tick();
        rst = 1'b1;
        for (int p = 1; p <= 257; p++) begin
            btn_raw = 1'b1;
            push_press();
            wait_for(0, 1'b1, 20, n);
            check("wrap_press_lat", 32'(n), 32'(LAT));
            if (p == 255) check("wrap_255", 32'(press_count), 32'd255);
            if (p == 256) check("wrap_256", 32'(press_count), 32'd0);
            if (p == 257) check("wrap_257", 32'(press_count), 32'd1);
            btn_raw = 1'b0;
            push_release();
            wait_for(0, 1'b0, 20, n);
            check("wrap_rel_lat", 32'(n), 32'(LAT));
            tick();
        end

        // 6a. reset during PRESS_CHK
        btn_raw = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("prechk_level", 32'(btn_level), 32'd0);
        rst = 1'b0;
        #1;
        all_zero("reset_presschk");
        exp_count = 8'd0;
        tick();
        rst = 1'b1;
        push_press();
        wait_for(0, 1'b1, 20, n);
        check("requal_lat_a", 32'(n), 32'(LAT));

        // 6b. reset during PRESSED with long_press set
        wait_for(1, 1'b1, 40, n);
        check("long_lat_6", 32'(n), 32'(LONG + 1));
        rst = 1'b0;
        #1;
        all_zero("reset_pressed");
        exp_count = 8'd0;
        tick();
        rst = 1'b1;
        push_press();
        wait_for(0, 1'b1, 20, n);
        check("requal_lat_b", 32'(n), 32'(LAT));
        check("requal_count", 32'(press_count), 32'd1);
        btn_raw = 1'b0;
        push_release();
        wait_for(0, 1'b0, 20, n);
        check("release_lat_6", 32'(n), 32'(LAT));

        tick();
        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
